fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner; single-outstanding instruction fetch with valid/ready
//            output to decode. Optional macro FETCH_MISALIGN_CHECK_EN adds
//            misaligned-redirect trapping (fetch_err_o, ERR state).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        pc_next_sel_i,
  input  logic        redirect_i,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_err_o,
`endif
  input  logic [31:0] redirect_pc_i
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc_o;
  logic [31:0] w_pc_o_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic        w_redir_ok;
  logic [31:0] w_redir_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        w_redir_bad;
`endif

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    w_redir_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    w_redir_ok  = redirect_i & ~w_redir_bad;
    w_redir_pc  = redirect_pc_i;
`else
    w_redir_ok  = redirect_i;
    w_redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
`endif
  end

  // A misaligned redirect suppresses the request in the same cycle so no
  // grant can be taken for a fetch that is about to be abandoned.
  always_comb begin
    mem_req_o = (r_state == ST_REQ) & ~rst_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    mem_req_o = mem_req_o & ~w_redir_bad;
    fetch_err_o = (r_state == ST_ERR);
`endif
  end

  assign mem_addr_o    = r_pc;
  assign instr_valid_o = (r_state == ST_VALID);
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_o;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_pc_o_nxt    = r_pc_o;
    w_discard_nxt = r_discard;
    case (r_state)
      ST_REQ: begin
        if (mem_req_o && mem_gnt_i) begin
          w_state_nxt = ST_WAIT;
          if (w_redir_ok) w_discard_nxt = 1'b1;
        end
        if (w_redir_ok) w_pc_nxt = w_redir_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_redir_bad) w_state_nxt = ST_ERR;
`endif
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          w_state_nxt   = ST_REQ;
          w_discard_nxt = 1'b0;
          if (!r_discard && !redirect_i) begin
            w_state_nxt = ST_VALID;
            w_instr_nxt = mem_rdata_i;
            w_pc_o_nxt  = r_pc;
          end
        end else if (redirect_i) begin
          w_discard_nxt = 1'b1;
        end
        if (w_redir_ok) w_pc_nxt = w_redir_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_redir_bad) w_state_nxt = ST_ERR;
`endif
      end
      ST_VALID: begin
        if (w_redir_ok) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REQ;
        end else if (instr_ready_i) begin
          w_state_nxt = ST_REQ;
          if (pc_next_sel_i) w_pc_nxt = r_pc + 32'd4;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_redir_bad) w_state_nxt = ST_ERR;
`endif
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_ERR: begin
        if (mem_rvalid_i) w_discard_nxt = 1'b0;
        if (w_redir_ok) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REQ;
        end
      end
`endif
      default: w_state_nxt = ST_REQ;
    endcase
  end

  // Reset landing in WAIT leaves a response in flight; the sticky discard
  // flag survives multi-cycle resets so that response is dropped later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_pc_o    <= 32'd0;
      r_discard <= (r_discard || (r_state == ST_WAIT)) && !mem_rvalid_i;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_pc_o    <= w_pc_o_nxt;
      r_discard <= w_discard_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        pc_next_sel_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_err_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_next_sel_i (pc_next_sel_i),
    .redirect_i    (redirect_i),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_err_o   (fetch_err_o),
`endif
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Zero-wait fetch from REQ: grant now, data next cycle, ends in VALID.
  task automatic quick_fetch(input logic [31:0] data);
    mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = data; tick; mem_rvalid_i = 1'b0;
  endtask

  task automatic accept(input logic sel);
    instr_ready_i = 1'b1; pc_next_sel_i = sel; tick; instr_ready_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; tick; tick; rst_i = 1'b0; #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) tick;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr_o); end
    checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL rst_pc_o: got %h want 0", pc_o); end
    checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
    rst_i = 1'b0; #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_rel_req: got %b want 1", mem_req_o); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = i * 4;
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== exp_pc) begin errors++; $display("FAIL zw_req[%0d]: got req %b addr %h want 1 %h", i, mem_req_o, mem_addr_o, exp_pc); end
      mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
      checks++; if (mem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL zw_wait[%0d]: got req %b valid %b want 0 0", i, mem_req_o, instr_valid_o); end
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000_0000 + i; tick; mem_rvalid_i = 1'b0;
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h1000_0000 + i || pc_o !== exp_pc) begin errors++; $display("FAIL zw_valid[%0d]: got v %b instr %h pc %h want 1 %h %h", i, instr_valid_o, instr_o, pc_o, 32'h1000_0000 + i, exp_pc); end
      accept(1'b1);
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL zw_drop[%0d]: got %b want 0", i, instr_valid_o); end
    end
  endtask

  task automatic test_wait_states;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL ws_hold[%0d]: got req %b addr %h want 1 0", i, mem_req_o, mem_addr_o); end
      tick;
    end
    mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
    tick;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL ws_wait: got v %b req %b want 0 0", instr_valid_o, mem_req_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0537; tick; mem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0537 || pc_o !== 32'h0) begin errors++; $display("FAIL ws_data: got v %b instr %h pc %h want 1 00000537 0", instr_valid_o, instr_o, pc_o); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0537 || pc_o !== 32'h0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL stall[%0d]: got v %b instr %h pc %h req %b", i, instr_valid_o, instr_o, pc_o, mem_req_o); end
    end
    accept(1'b1);
    checks++; if (mem_addr_o !== 32'h4) begin errors++; $display("FAIL stall_inc: got %h want 4", mem_addr_o); end
    quick_fetch(32'h0000_0013);
    checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL stall_pc4: got %h want 4", pc_o); end
    accept(1'b0);
    checks++; if (mem_addr_o !== 32'h4 || mem_req_o !== 1'b1) begin errors++; $display("FAIL same_sel: got addr %h req %b want 4 1", mem_addr_o, mem_req_o); end
  endtask

  task automatic test_redirect_wait;
    quick_fetch(32'h0000_0013);
    accept(1'b1);
    mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h100; tick; redirect_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL rw_wait: got req %b addr %h want 0 100", mem_req_o, mem_addr_o); end
    tick;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; tick; mem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL rw_drop: got v %b req %b addr %h want 0 1 100", instr_valid_o, mem_req_o, mem_addr_o); end
    quick_fetch(32'h0000_0093);
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h0000_0093) begin errors++; $display("FAIL rw_new: got v %b pc %h instr %h want 1 100 00000093", instr_valid_o, pc_o, instr_o); end
  endtask

  task automatic test_redirect_accept;
    instr_ready_i = 1'b1; pc_next_sel_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick;
    instr_ready_i = 1'b0; redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'h200 || mem_req_o !== 1'b1) begin errors++; $display("FAIL ra_addr: got v %b addr %h req %b want 0 200 1", instr_valid_o, mem_addr_o, mem_req_o); end
    mem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300; tick;
    mem_gnt_i = 1'b0; redirect_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h300) begin errors++; $display("FAIL rq_grant: got req %b addr %h want 0 300", mem_req_o, mem_addr_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0200; tick; mem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL rq_drop: got v %b req %b want 0 1", instr_valid_o, mem_req_o); end
    quick_fetch(32'h0000_0300);
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h300) begin errors++; $display("FAIL rq_new: got v %b pc %h want 1 300", instr_valid_o, pc_o); end
  endtask

  task automatic test_reset_mid_wait;
    accept(1'b1);
    mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
    rst_i = 1'b1; tick; rst_i = 1'b0; #1;
    checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL rm_rst: got v %b addr %h req %b want 0 0 1", instr_valid_o, mem_addr_o, mem_req_o); end
    tick;
    mem_gnt_i = 1'b1; tick; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0304; tick; mem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_stale: got v %b req %b addr %h want 0 1 0", instr_valid_o, mem_req_o, mem_addr_o); end
    quick_fetch(32'h0000_0013);
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== 32'h0) begin errors++; $display("FAIL rm_fetch: got v %b instr %h pc %h want 1 00000013 0", instr_valid_o, instr_o, pc_o); end
  endtask

  task automatic test_wrap;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; tick; redirect_i = 1'b0;
    checks++; if (mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir: got %h want fffffffc", mem_addr_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; tick; mem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL rv_in_req: got v %b req %b want 0 1", instr_valid_o, mem_req_o); end
    quick_fetch(32'h0000_0073);
    checks++; if (pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h0000_0073) begin errors++; $display("FAIL wrap_pc: got pc %h instr %h want fffffffc 00000073", pc_o, instr_o); end
    accept(1'b1);
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_inc: got %h want 0", mem_addr_o); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign;
    redirect_i = 1'b1; redirect_pc_i = 32'h102; #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL ma_req_now: got %b want 0", mem_req_o); end
    tick; redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_err_o !== 1'b1 || mem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL ma_err[%0d]: got err %b req %b v %b addr %h", i, fetch_err_o, mem_req_o, instr_valid_o, mem_addr_o); end
      tick;
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h104; tick; redirect_i = 1'b0;
    checks++; if (fetch_err_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin errors++; $display("FAIL ma_clear: got err %b req %b addr %h want 0 1 104", fetch_err_o, mem_req_o, mem_addr_o); end
  endtask
`else
  task automatic test_misalign;
    redirect_i = 1'b1; redirect_pc_i = 32'h103; tick; redirect_i = 1'b0;
    checks++; if (mem_addr_o !== 32'h100 || mem_req_o !== 1'b1) begin errors++; $display("FAIL ma_force: got addr %h req %b want 100 1", mem_addr_o, mem_req_o); end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_stall;
    test_redirect_wait;
    test_redirect_accept;
    test_reset_mid_wait;
    test_wrap;
    test_misalign;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
